// File: rtl/bpu_if.sv
// Front-end / execute-side bundle for the branch prediction unit.
// The master side issues queries, flushes and resolved updates; the slave
// side (the BPU) returns the registered prediction and statistics.
interface bpu_if #(
   parameter int unsigned CNT_W = 32
);
   logic             req_valid;
   logic [63:0]      req_pc;
   logic             resp_valid;
   logic             resp_taken;
   logic [63:0]      resp_target;
   logic             flush;
   logic             upd_valid;
   logic [63:0]      upd_pc;
   logic             upd_branch;
   logic             upd_jump;
   logic             upd_taken;
   logic [63:0]      upd_target;
   logic             upd_mispredict;
   logic [CNT_W-1:0] stat_ctrl;
   logic [CNT_W-1:0] stat_miss;

   modport master (
      output req_valid, req_pc, flush,
      output upd_valid, upd_pc, upd_branch, upd_jump, upd_taken, upd_target, upd_mispredict,
      input  resp_valid, resp_taken, resp_target, stat_ctrl, stat_miss
   );

   modport slave (
      input  req_valid, req_pc, flush,
      input  upd_valid, upd_pc, upd_branch, upd_jump, upd_taken, upd_target, upd_mispredict,
      output resp_valid, resp_taken, resp_target, stat_ctrl, stat_miss
   );
endinterface

// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with a 2-bit bimodal counter per
// entry. Lookup is registered (1-cycle latency) and write-first against an
// update to the same index in the same cycle. ENTRIES must be a power of two >= 2.
module bpu #(
   parameter int unsigned ENTRIES  = 64,
   parameter int unsigned TAG_BITS = 10,
   parameter int unsigned CNT_W    = 32
) (
   input logic  clk,
   input logic  reset,
   bpu_if.slave bus
);
   localparam int unsigned IDX = $clog2(ENTRIES);

   // Entry storage; only the valid bits need reset.
   logic [ENTRIES-1:0]  r_valid;
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [63:0]         r_target [ENTRIES];
   logic [1:0]          r_cnt    [ENTRIES];
   logic                r_jump   [ENTRIES];

   logic                r_resp_valid;
   logic                r_resp_taken;
   logic [63:0]         r_resp_target;
   logic [CNT_W-1:0]    r_stat_ctrl;
   logic [CNT_W-1:0]    r_stat_miss;

   logic [IDX-1:0]      w_req_idx;
   logic [TAG_BITS-1:0] w_req_tag;
   logic [IDX-1:0]      w_upd_idx;
   logic [TAG_BITS-1:0] w_upd_tag;
   logic                w_ctrl;
   logic                w_upd_hit;
   logic [1:0]          w_old_cnt;
   logic                w_wr_en;
   logic [63:0]         w_new_target;
   logic [1:0]          w_new_cnt;
   logic                w_new_jump;
   logic                w_bypass;
   logic                w_hit;
   logic [63:0]         w_ent_target;
   logic [1:0]          w_ent_cnt;
   logic                w_ent_jump;
   logic                w_taken;
   logic [63:0]         w_next_target;
   logic                w_unused;

   assign w_req_idx = bus.req_pc[IDX+1:2];
   assign w_req_tag = bus.req_pc[IDX+TAG_BITS+1:IDX+2];
   assign w_upd_idx = bus.upd_pc[IDX+1:2];
   assign w_upd_tag = bus.upd_pc[IDX+TAG_BITS+1:IDX+2];
   assign w_ctrl    = bus.upd_valid & (bus.upd_branch | bus.upd_jump);
   assign w_unused  = ^{bus.upd_pc[63:IDX+TAG_BITS+2], bus.upd_pc[1:0]};

   // Next contents of the updated entry and whether it is written at all.
   // A jump flag wins over the branch flag when both are set.
   always_comb begin
      w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
      w_old_cnt    = r_cnt[w_upd_idx];
      w_wr_en      = 1'b0;
      w_new_target = r_target[w_upd_idx];
      w_new_cnt    = w_old_cnt;
      w_new_jump   = r_jump[w_upd_idx];
      if (w_ctrl) begin
         if (w_upd_hit) begin
            w_wr_en = 1'b1;
            if (bus.upd_jump) begin
               w_new_jump   = 1'b1;
               w_new_target = bus.upd_target;
               w_new_cnt    = 2'd3;
            end else if (bus.upd_taken) begin
               w_new_target = bus.upd_target;
               w_new_cnt    = (w_old_cnt == 2'd3) ? 2'd3 : w_old_cnt + 2'd1;
            end else begin
               w_new_cnt    = (w_old_cnt == 2'd0) ? 2'd0 : w_old_cnt - 2'd1;
            end
         end else if (bus.upd_jump || bus.upd_taken) begin
            // Allocate on taken miss; not-taken misses leave the array alone.
            w_wr_en      = 1'b1;
            w_new_target = bus.upd_target;
            w_new_jump   = bus.upd_jump;
            w_new_cnt    = bus.upd_jump ? 2'd3 : 2'd2;
         end
      end
   end

   // Lookup with write-first forwarding from a same-index update.
   always_comb begin
      w_bypass = w_wr_en && (w_upd_idx == w_req_idx);
      if (w_bypass) begin
         w_hit        = (w_upd_tag == w_req_tag);
         w_ent_target = w_new_target;
         w_ent_cnt    = w_new_cnt;
         w_ent_jump   = w_new_jump;
      end else begin
         w_hit        = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
         w_ent_target = r_target[w_req_idx];
         w_ent_cnt    = r_cnt[w_req_idx];
         w_ent_jump   = r_jump[w_req_idx];
      end
      w_taken       = w_hit & (w_ent_jump | w_ent_cnt[1]);
      w_next_target = w_taken ? w_ent_target : bus.req_pc + 64'd4;
   end

   // Valid bits: cleared by reset, set on any entry write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else if (w_wr_en) begin
         r_valid[w_upd_idx] <= 1'b1;
      end
   end

   // Entry payload; contents are irrelevant while the valid bit is clear.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_tag[w_upd_idx]    <= w_upd_tag;
         r_target[w_upd_idx] <= w_new_target;
         r_cnt[w_upd_idx]    <= w_new_cnt;
         r_jump[w_upd_idx]   <= w_new_jump;
      end
   end

   // Registered prediction response; flush kills the in-flight response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_resp_valid  <= 1'b0;
         r_resp_taken  <= 1'b0;
         r_resp_target <= '0;
      end else begin
         r_resp_valid  <= bus.req_valid & ~bus.flush;
         r_resp_taken  <= w_taken;
         r_resp_target <= w_next_target;
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_ctrl <= '0;
         r_stat_miss <= '0;
      end else begin
         if (w_ctrl && (r_stat_ctrl != '1)) begin
            r_stat_ctrl <= r_stat_ctrl + 1'b1;
         end
         if (bus.upd_valid && bus.upd_mispredict && (r_stat_miss != '1)) begin
            r_stat_miss <= r_stat_miss + 1'b1;
         end
      end
   end

   assign bus.resp_valid  = r_resp_valid;
   assign bus.resp_taken  = r_resp_taken;
   assign bus.resp_target = r_resp_target;
   assign bus.stat_ctrl   = r_stat_ctrl;
   assign bus.stat_miss   = r_stat_miss;
endmodule
